// File: rtl/serial_fifo_bridge_if.sv
`default_nettype none
// ============================================================================
// Module   : serial_fifo_bridge_if
// Purpose  : Bundles the MMU access port and the UART request port of the bridge.
// Revision : 1.0
// ============================================================================
interface serial_fifo_bridge_if;
    logic        mmu_enable_i;
    logic        mmu_readWrite_i;
    logic        mmu_sel_i;
    logic [15:0] mmu_dataWrite_i;
    logic [15:0] mmu_dataRead_o;
    logic [15:0] uart_sendData_o;
    logic        uart_readWrite_o;
    logic        uart_enable_o;
    logic        uart_sendComplete_i;
    logic        uart_receiveComplete_i;
    logic [15:0] uart_receiveData_i;

    modport slave (
        input  mmu_enable_i, mmu_readWrite_i, mmu_sel_i, mmu_dataWrite_i,
        input  uart_sendComplete_i, uart_receiveComplete_i, uart_receiveData_i,
        output mmu_dataRead_o, uart_sendData_o, uart_readWrite_o, uart_enable_o
    );

    modport master (
        output mmu_enable_i, mmu_readWrite_i, mmu_sel_i, mmu_dataWrite_i,
        output uart_sendComplete_i, uart_receiveComplete_i, uart_receiveData_i,
        input  mmu_dataRead_o, uart_sendData_o, uart_readWrite_o, uart_enable_o
    );
endinterface
`default_nettype wire

// File: rtl/serial_fifo_bridge.sv
`default_nettype none
// ============================================================================
// Module   : serial_fifo_bridge
// Purpose  : TX/RX byte FIFOs between the MMU serial port and the UART controller.
// Revision : 1.0
// ============================================================================
module serial_fifo_bridge #(
    parameter int DEPTH       = 8,
    parameter int POLL_CYCLES = 16
) (
    input  wire logic          clk,
    input  wire logic          rst,
    serial_fifo_bridge_if.slave bus
);
    localparam int c_AW = $clog2(DEPTH);
    localparam int c_CW = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
    localparam logic [c_AW:0]   c_PTR_ONE   = 1;
    localparam logic [c_CW-1:0] c_CNT_ONE   = 1;
    localparam logic [c_CW-1:0] c_POLL_LAST = c_CW'(POLL_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_RECV = 2'd2
    } state_t;

    state_t            r_state;
    logic [7:0]        r_tx_mem [DEPTH];
    logic [7:0]        r_rx_mem [DEPTH];
    logic [c_AW:0]     r_tx_wr, r_tx_rd, r_rx_wr, r_rx_rd;
    logic              r_ovf;
    logic              r_uart_en;
    logic              r_uart_rw;
    logic [7:0]        r_send_data;
    logic [c_CW-1:0]   r_poll_cnt;

    logic w_tx_empty, w_tx_full, w_rx_empty, w_rx_full;
    logic w_data_wr, w_data_rd, w_stat_rd;
    logic w_tx_push, w_tx_pop, w_rx_push, w_rx_pop, w_ovf_set;
    logic [7:0] w_tx_head, w_rx_head;
    logic w_unused;

    assign w_tx_empty = (r_tx_wr == r_tx_rd);
    assign w_tx_full  = (r_tx_wr[c_AW] != r_tx_rd[c_AW]) &&
                        (r_tx_wr[c_AW-1:0] == r_tx_rd[c_AW-1:0]);
    assign w_rx_empty = (r_rx_wr == r_rx_rd);
    assign w_rx_full  = (r_rx_wr[c_AW] != r_rx_rd[c_AW]) &&
                        (r_rx_wr[c_AW-1:0] == r_rx_rd[c_AW-1:0]);

    assign w_data_wr = bus.mmu_enable_i &  bus.mmu_readWrite_i & ~bus.mmu_sel_i;
    assign w_data_rd = bus.mmu_enable_i & ~bus.mmu_readWrite_i & ~bus.mmu_sel_i;
    assign w_stat_rd = bus.mmu_enable_i & ~bus.mmu_readWrite_i &  bus.mmu_sel_i;

    // A full TX that is being drained this cycle still has room for the write.
    assign w_tx_pop  = (r_state == S_SEND) & bus.uart_sendComplete_i;
    assign w_tx_push = w_data_wr & (~w_tx_full | w_tx_pop);
    assign w_ovf_set = w_data_wr & w_tx_full & ~w_tx_pop;
    assign w_rx_push = (r_state == S_RECV) & bus.uart_receiveComplete_i;
    assign w_rx_pop  = w_data_rd & ~w_rx_empty;

    assign w_tx_head = r_tx_mem[r_tx_rd[c_AW-1:0]];
    assign w_rx_head = r_rx_mem[r_rx_rd[c_AW-1:0]];

    assign bus.mmu_dataRead_o   = bus.mmu_sel_i ? {13'b0, r_ovf, ~w_rx_empty, ~w_tx_full}
                                : (w_rx_empty ? 16'h0000 : {8'h00, w_rx_head});
    assign bus.uart_sendData_o  = {8'h00, r_send_data};
    assign bus.uart_enable_o    = r_uart_en;
    assign bus.uart_readWrite_o = r_uart_rw;

    assign w_unused = ^{bus.mmu_dataWrite_i[15:8], bus.uart_receiveData_i[15:8]};

    always_ff @(posedge clk) begin
        if (w_tx_push) r_tx_mem[r_tx_wr[c_AW-1:0]] <= bus.mmu_dataWrite_i[7:0];
        if (w_rx_push) r_rx_mem[r_rx_wr[c_AW-1:0]] <= bus.uart_receiveData_i[7:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tx_wr <= '0;
            r_tx_rd <= '0;
            r_rx_wr <= '0;
            r_rx_rd <= '0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_tx_push) r_tx_wr <= r_tx_wr + c_PTR_ONE;
            if (w_tx_pop)  r_tx_rd <= r_tx_rd + c_PTR_ONE;
            if (w_rx_push) r_rx_wr <= r_rx_wr + c_PTR_ONE;
            if (w_rx_pop)  r_rx_rd <= r_rx_rd + c_PTR_ONE;
            r_ovf <= w_ovf_set | (r_ovf & ~w_stat_rd);
        end
    end

    // Every exit to IDLE clears the enable so the UART always sees a falling edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_uart_en   <= 1'b0;
            r_uart_rw   <= 1'b0;
            r_send_data <= 8'h00;
            r_poll_cnt  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (!w_tx_empty) begin
                        r_state     <= S_SEND;
                        r_uart_en   <= 1'b1;
                        r_uart_rw   <= 1'b1;
                        r_send_data <= w_tx_head;
                    end else if (!w_rx_full) begin
                        r_state    <= S_RECV;
                        r_uart_en  <= 1'b1;
                        r_uart_rw  <= 1'b0;
                        r_poll_cnt <= '0;
                    end
                end
                S_SEND: begin
                    if (bus.uart_sendComplete_i) begin
                        r_state   <= S_IDLE;
                        r_uart_en <= 1'b0;
                        r_uart_rw <= 1'b0;
                    end
                end
                S_RECV: begin
                    if (bus.uart_receiveComplete_i) begin
                        r_state   <= S_IDLE;
                        r_uart_en <= 1'b0;
                    end else if (!w_tx_empty) begin
                        if (r_poll_cnt == c_POLL_LAST) begin
                            r_state   <= S_IDLE;
                            r_uart_en <= 1'b0;
                        end else begin
                            r_poll_cnt <= r_poll_cnt + c_CNT_ONE;
                        end
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_uart_en <= 1'b0;
                    r_uart_rw <= 1'b0;
                end
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_serial_fifo_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_fifo_bridge
// Purpose  : Scoreboard bench for serial_fifo_bridge against a queue-based model.
// Revision : 1.0
// ============================================================================
module tb_serial_fifo_bridge;
    localparam int DEPTH = 8;
    localparam int POLL  = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    serial_fifo_bridge_if bus();
    serial_fifo_bridge #(.DEPTH(DEPTH), .POLL_CYCLES(POLL)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int tests = 0;
    int fails = 0;

    // Reference model: byte queues plus the sticky flag.
    logic [7:0]  m_tx_q[$];
    int          m_tx_cnt = 0;
    logic [7:0]  m_rx_q[$];
    bit          m_ovf = 1'b0;
    logic [15:0] sb_rd_q[$];

    bit uart_ok    = 1'b1;
    int send_delay = 5;
    int send_cnt   = 0;
    bit spur       = 1'b0;
    bit prev_send  = 1'b0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compares every read access and every new send request.
    always @(negedge clk) begin
        logic [15:0] e;
        bit s;
        if (!rst) begin
            if (bus.mmu_enable_i && !bus.mmu_readWrite_i) begin
                if (sb_rd_q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL rd_unexpected: got %h, expected no read", bus.mmu_dataRead_o);
                end else begin
                    e = sb_rd_q.pop_front();
                    check(bus.mmu_sel_i ? "status_rd" : "data_rd", bus.mmu_dataRead_o, e);
                end
            end
            s = bus.uart_enable_o && bus.uart_readWrite_o;
            if (s && !prev_send) begin
                if (m_tx_q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL send_unexpected: got %h, expected no send", bus.uart_sendData_o);
                end else begin
                    check("send_byte", bus.uart_sendData_o, {8'h00, m_tx_q.pop_front()});
                end
            end
            prev_send = s;
        end else begin
            prev_send = 1'b0;
        end
    end

    // op: 0 idle, 1 data write, 2 data read, 3 status read, 4 status write
    task automatic cycle(input int op, input logic [7:0] wb, input bit rxp, input logic [7:0] rxb);
        bit in_send = bus.uart_enable_o && bus.uart_readWrite_o;
        bit in_recv = bus.uart_enable_o && !bus.uart_readWrite_o;
        bit sc = 1'b0;
        bit tx_full = (m_tx_cnt == DEPTH);
        bit done;
        logic [15:0] junk = 16'($urandom);
        if (in_send) begin
            send_cnt++;
            if (uart_ok && send_cnt >= send_delay) begin
                sc = 1'b1;
                send_cnt = 0;
            end
        end else begin
            send_cnt = 0;
            if (spur && $urandom_range(0, 7) == 0) sc = 1'b1;
        end
        bus.uart_sendComplete_i    = sc;
        bus.uart_receiveComplete_i = rxp;
        bus.uart_receiveData_i     = {junk[15:8], rxb};
        bus.mmu_enable_i    = (op != 0);
        bus.mmu_readWrite_i = (op == 1 || op == 4);
        bus.mmu_sel_i       = (op >= 3);
        bus.mmu_dataWrite_i = {junk[7:0], wb};
        case (op)
            1: if (!tx_full || (sc && in_send)) begin
                   m_tx_q.push_back(wb);
                   m_tx_cnt++;
               end else begin
                   m_ovf = 1'b1;
               end
            2: sb_rd_q.push_back((m_rx_q.size() != 0) ? {8'h00, m_rx_q.pop_front()} : 16'h0000);
            3: begin
                   sb_rd_q.push_back({13'b0, m_ovf, m_rx_q.size() != 0, !tx_full});
                   m_ovf = 1'b0;
               end
            default: ;
        endcase
        if (sc && in_send) m_tx_cnt--;
        if (rxp && in_recv) m_rx_q.push_back(rxb);
        done = (sc && in_send) || (rxp && in_recv);
        @(posedge clk);
        #1;
        bus.mmu_enable_i           = 1'b0;
        bus.mmu_sel_i              = 1'b0;
        bus.uart_sendComplete_i    = 1'b0;
        bus.uart_receiveComplete_i = 1'b0;
        if (done) check("idle_after_done", {15'b0, bus.uart_enable_o}, 16'h0000);
    endtask

    task automatic drain();
        for (int i = 0; i < 3000 && m_tx_cnt != 0; i++) cycle(0, 8'h00, 1'b0, 8'h00);
        check("drain_tx_count", 16'(m_tx_cnt), 16'h0000);
        repeat (3) cycle(0, 8'h00, 1'b0, 8'h00);
        check("all_sent", 16'(m_tx_q.size()), 16'h0000);
    endtask

    task automatic reach_recv();
        for (int i = 0; i < 40 && !(bus.uart_enable_o && !bus.uart_readWrite_o); i++)
            cycle(0, 8'h00, 1'b0, 8'h00);
        check("reach_recv", {14'b0, bus.uart_enable_o, bus.uart_readWrite_o}, 16'h0002);
    endtask

    task automatic abandon_test(input logic [7:0] b, input bit capture, input logic [7:0] rb);
        reach_recv();
        cycle(1, b, 1'b0, 8'h00);
        for (int i = 0; i < POLL - 1; i++) begin
            check("abandon_recv", {14'b0, bus.uart_enable_o, bus.uart_readWrite_o}, 16'h0002);
            cycle(0, 8'h00, 1'b0, 8'h00);
        end
        check("abandon_recv", {14'b0, bus.uart_enable_o, bus.uart_readWrite_o}, 16'h0002);
        cycle(0, 8'h00, capture, rb);
        check("abandon_idle", {15'b0, bus.uart_enable_o}, 16'h0000);
        cycle(0, 8'h00, 1'b0, 8'h00);
        check("abandon_send", {14'b0, bus.uart_enable_o, bus.uart_readWrite_o}, 16'h0003);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        bus.mmu_enable_i = 0; bus.mmu_readWrite_i = 0; bus.mmu_sel_i = 1;
        bus.mmu_dataWrite_i = 0; bus.uart_sendComplete_i = 0;
        bus.uart_receiveComplete_i = 0; bus.uart_receiveData_i = 0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_en", {15'b0, bus.uart_enable_o}, 16'h0000);
        check("reset_status", bus.mmu_dataRead_o, 16'h0001);
        bus.mmu_sel_i = 0;
        #1;
        check("reset_data", bus.mmu_dataRead_o, 16'h0000);
        check("reset_send_data", bus.uart_sendData_o, 16'h0000);
        rst = 1'b0;
        check("release_en", {15'b0, bus.uart_enable_o}, 16'h0000);
        repeat (3) cycle(0, 8'h00, 1'b0, 8'h00);
        check("recv_after_reset", {14'b0, bus.uart_enable_o, bus.uart_readWrite_o}, 16'h0002);

        // Two ordered sends, completion 5 cycles after each enable.
        cycle(1, 8'h41, 1'b0, 8'h00);
        cycle(1, 8'h42, 1'b0, 8'h00);
        drain();
        cycle(3, 8'h00, 1'b0, 8'h00);

        // Overflow with the UART stalled.
        uart_ok = 1'b0;
        for (int i = 0; i < DEPTH + 1; i++) cycle(1, 8'(8'h60 + i), 1'b0, 8'h00);
        cycle(3, 8'h00, 1'b0, 8'h00);
        cycle(3, 8'h00, 1'b0, 8'h00);
        uart_ok = 1'b1;
        send_delay = 2;
        drain();

        // Receive path.
        reach_recv();
        cycle(0, 8'h00, 1'b1, 8'h5A);
        cycle(3, 8'h00, 1'b0, 8'h00);
        cycle(2, 8'h00, 1'b0, 8'h00);
        cycle(2, 8'h00, 1'b0, 8'h00);

        // Poll abandon, then abandon coinciding with a receive.
        abandon_test(8'h77, 1'b0, 8'h00);
        drain();
        abandon_test(8'h88, 1'b1, 8'hC3);
        drain();
        cycle(2, 8'h00, 1'b0, 8'h00);
        cycle(3, 8'h00, 1'b0, 8'h00);

        // Asynchronous reset while sending; RX contents must be discarded.
        reach_recv();
        cycle(0, 8'h00, 1'b1, 8'h11);
        uart_ok = 1'b0;
        reach_recv();
        cycle(1, 8'h99, 1'b0, 8'h00);
        for (int i = 0; i < 40 && !(bus.uart_enable_o && bus.uart_readWrite_o); i++)
            cycle(0, 8'h00, 1'b0, 8'h00);
        check("reach_send", {14'b0, bus.uart_enable_o, bus.uart_readWrite_o}, 16'h0003);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("async_reset_en", {15'b0, bus.uart_enable_o}, 16'h0000);
        m_tx_q.delete(); m_rx_q.delete(); m_tx_cnt = 0; m_ovf = 1'b0; send_cnt = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        uart_ok = 1'b1;
        cycle(3, 8'h00, 1'b0, 8'h00);
        cycle(2, 8'h00, 1'b0, 8'h00);

        // Randomised traffic including spurious completion pulses.
        spur = 1'b1;
        for (int i = 0; i < 600; i++) begin
            int r = $urandom_range(0, 9);
            int op = (r < 4) ? 1 : (r < 6) ? 2 : (r == 6) ? 3 : (r == 7) ? 4 : 0;
            send_delay = $urandom_range(1, 4);
            cycle(op, 8'($urandom_range(0, 255)), ($urandom_range(0, 3) == 0),
                  8'($urandom_range(0, 255)));
        end
        spur = 1'b0;
        drain();
        for (int i = 0; i < DEPTH + 2; i++) cycle(2, 8'h00, 1'b0, 8'h00);
        cycle(3, 8'h00, 1'b0, 8'h00);
        cycle(3, 8'h00, 1'b0, 8'h00);
        repeat (2) cycle(0, 8'h00, 1'b0, 8'h00);
        check("rd_scoreboard_empty", 16'(sb_rd_q.size()), 16'h0000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
`default_nettype wire
